// File: rtl/cnt_seq.sv
// -----------------------------------------------------------------------------
// cnt_seq -- command sequencer for a loadable up-counter.
//
// Accepts (start, length) commands over a valid/ready handshake. For each
// command the counter is loaded with `start`, then enabled for exactly
// `length` cycles, and completion is signalled with a one-cycle `done` pulse.
// `abort` cancels a command that is in LOAD or RUN.
//
// Optional feature (macro CNT_SEQ_CHECK_EN):
//   defined     -> the expected final count is kept and compared against the
//                  counter feedback in DONE; `err` pulses and `err_sticky`
//                  latches on a mismatch.
//   not defined -> no expected-value register, `cnt_q` is ignored,
//                  `err`/`err_sticky` are tied low.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   sequencer can accept a command (IDLE only)
//   cmd_start   value loaded into the counter
//   cmd_len     number of enable cycles (0 .. 2^WIDTH-1)
//   abort       cancel the command in progress (LOAD/RUN only)
//   cnt_rst     counter rst (active-high), asserted in INIT
//   cnt_load    counter load, asserted in LOAD
//   cnt_enab    counter enab, asserted in RUN
//   cnt_val     counter cnt_in, last captured start (0 after reset)
//   cnt_q       counter cnt_out feedback
//   busy        high in LOAD, RUN and DONE
//   done        one-cycle completion pulse (DONE state)
//   aborted     one-cycle pulse the cycle after an accepted abort
//   err         one-cycle pulse the cycle after a failed final-count check
//   err_sticky  latched mismatch, cleared only by reset
// -----------------------------------------------------------------------------
module cnt_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic             abort,
  output logic             cnt_rst,
  output logic             cnt_load,
  output logic             cnt_enab,
  output logic [WIDTH-1:0] cnt_val,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic             err_sticky
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] start_reg, start_next;
  logic [WIDTH-1:0] remain_reg, remain_next;
  logic             aborted_reg;
  logic             abort_hit;
  logic             accept;

  assign accept    = (state_reg == IDLE) && cmd_valid;
  // abort only has an effect while a command is actually driving the counter
  assign abort_hit = abort && ((state_reg == LOAD) || (state_reg == RUN));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    start_next  = start_reg;
    remain_next = remain_reg;
    case (state_reg)
      INIT: state_next = IDLE;
      IDLE: begin
        if (cmd_valid) begin
          start_next  = cmd_start;
          remain_next = cmd_len;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        // remain still holds the captured length here
        if (abort_hit)               state_next = IDLE;
        else if (remain_reg != '0)   state_next = RUN;
        else                         state_next = DONE;
      end
      RUN: begin
        remain_next = remain_reg - 1'b1;
        // abort wins over the normal exit on the last enable cycle
        if (abort_hit)               state_next = IDLE;
        else if (remain_reg == 1)    state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= INIT;
      start_reg   <= '0;
      remain_reg  <= '0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_reg   <= start_next;
      remain_reg  <= remain_next;
      aborted_reg <= abort_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decodes
  // ---------------------------------------------------------------------------
  assign cnt_rst   = (state_reg == INIT);
  assign cmd_ready = (state_reg == IDLE);
  assign cnt_load  = (state_reg == LOAD);
  assign cnt_enab  = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign busy      = (state_reg == LOAD) || (state_reg == RUN) || (state_reg == DONE);
  assign cnt_val   = start_reg;
  assign aborted   = aborted_reg;

  // ---------------------------------------------------------------------------
  // Final-count checker
  // ---------------------------------------------------------------------------
`ifdef CNT_SEQ_CHECK_EN
  logic [WIDTH-1:0] expect_reg, expect_next;
  logic             err_reg, err_sticky_reg;
  logic             mismatch;

  always_comb begin
    expect_next = expect_reg;
    if (accept) expect_next = WIDTH'(cmd_start + cmd_len);  // wraps mod 2^WIDTH
  end

  // the counter registers its controls one edge late, so cnt_q is final in DONE
  assign mismatch = (state_reg == DONE) && (cnt_q != expect_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      expect_reg     <= '0;
      err_reg        <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      expect_reg     <= expect_next;
      err_reg        <= mismatch;
      err_sticky_reg <= err_sticky_reg | mismatch;
    end
  end

  assign err        = err_reg;
  assign err_sticky = err_sticky_reg;
`else
  logic unused_check;
  assign unused_check = ^{cnt_q, accept};
  assign err          = 1'b0;
  assign err_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_seq.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq -- self-checking bench for cnt_seq.
// A behavioural loadable up-counter closes the loop on the cnt_* controls.
// Each command's expected behaviour (load/enable/done/abort timing, final
// count, error pulse) is derived arithmetically from start, length and the
// abort cycle, and compared against what is observed on the ports.
// -----------------------------------------------------------------------------
module tb_cnt_seq;
  localparam int WIDTH = 5;
  localparam int MOD   = 1 << WIDTH;
`ifdef CNT_SEQ_CHECK_EN
  localparam bit CHECK_BUILT = 1'b1;
`else
  localparam bit CHECK_BUILT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_len;
  logic             abort;
  logic             cnt_rst;
  logic             cnt_load;
  logic             cnt_enab;
  logic [WIDTH-1:0] cnt_val;
  logic [WIDTH-1:0] cnt_q;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;
  logic             err_sticky;

  // environment counter, with an override used to corrupt the feedback
  logic [WIDTH-1:0] cnt_model;
  logic             force_en;
  logic [WIDTH-1:0] force_val;
  assign cnt_q = force_en ? force_val : cnt_model;

  always @(posedge clk) begin
    if (cnt_rst)       cnt_model <= '0;
    else if (cnt_load) cnt_model <= cnt_val;
    else if (cnt_enab) cnt_model <= cnt_model + 1'b1;
  end

  cnt_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .abort(abort),
    .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_enab(cnt_enab),
    .cnt_val(cnt_val), .cnt_q(cnt_q),
    .busy(busy), .done(done), .aborted(aborted),
    .err(err), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit sticky_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold reset for ncyc edges, checking the INIT output values, then release
  task automatic do_reset(input int ncyc);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    force_en  = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      check("rst_cnt_rst", cnt_rst, 1);
      check("rst_ready", cmd_ready, 0);
      check("rst_flags", {cnt_load, cnt_enab, busy, done, aborted, err, err_sticky}, 0);
      check("rst_cnt_val", cnt_val, 0);
    end
    rst_n        = 1'b1;
    sticky_model = 1'b0;
    tick();
    check("rst_idle_ready", cmd_ready, 1);
    check("rst_cnt_q", cnt_q, 0);
    check("rst_sticky", err_sticky, 0);
    $display("reset cycles=%0d", ncyc);
  endtask

  // abort_at: cycle after the handshake (1 = LOAD) in which abort is held, 0 = none
  task automatic run_cmd(input int start, input int len, input int abort_at, input bit force_bad);
    int wait_n = 0;
    bit is_abt;
    int exp_enab, exp_final, exp_busy, exp_done_q, ready_k;
    bit exp_err;
    int n_load = 0, n_enab = 0, n_busy = 0, n_done = 0, n_abt = 0, n_err = 0;
    int load_val = -1, first_enab = -1, last_enab = -1;
    int done_k = -1, done_q = -1, abt_k = -1, err_k = -1;
    int ready_at = -1, ready_before = -1;

    is_abt     = (abort_at > 0);
    exp_enab   = is_abt ? abort_at - 1 : len;
    exp_final  = (start + exp_enab) % MOD;
    exp_busy   = is_abt ? abort_at : len + 2;
    exp_done_q = force_bad ? 9 : exp_final;
    exp_err    = CHECK_BUILT && !is_abt && force_bad && (exp_final != 9);
    ready_k    = is_abt ? abort_at + 1 : len + 3;
    force_val  = WIDTH'(9);

    while (!cmd_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    check("ready_wait", cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_start = WIDTH'(start);
    cmd_len   = WIDTH'(len);
    tick();                              // handshake edge
    cmd_valid = 1'b0;
    cmd_start = WIDTH'($urandom);
    cmd_len   = WIDTH'($urandom);

    for (int k = 1; k <= len + 4; k++) begin
      if (cnt_load) begin n_load++; load_val = int'(cnt_val); end
      if (cnt_enab) begin
        n_enab++;
        if (first_enab < 0) first_enab = k;
        last_enab = k;
      end
      if (busy)    n_busy++;
      if (done)    begin n_done++; done_k = k; done_q = int'(cnt_q); end
      if (aborted) begin n_abt++;  abt_k  = k; end
      if (err)     begin n_err++;  err_k  = k; end
      if (k == ready_k)     ready_at     = int'(cmd_ready);
      if (k == ready_k - 1) ready_before = int'(cmd_ready);
      abort    = (k == abort_at);
      // keep the corrupt feedback in place across the edge that ends DONE
      force_en = force_bad && (k == len + 1 || k == len + 2);
      tick();
    end
    abort    = 1'b0;
    force_en = 1'b0;

    check("load_count", n_load, 1);
    check("load_val", load_val, start);
    check("enab_count", n_enab, exp_enab);
    if (exp_enab > 0) begin
      check("enab_first", first_enab, 2);
      check("enab_last", last_enab, exp_enab + 1);
    end
    check("busy_cycles", n_busy, exp_busy);
    check("done_count", n_done, is_abt ? 0 : 1);
    if (!is_abt) begin
      check("done_cycle", done_k, len + 2);
      check("done_cnt_q", done_q, exp_done_q);
    end
    check("aborted_count", n_abt, is_abt ? 1 : 0);
    if (is_abt) check("aborted_cycle", abt_k, abort_at + 1);
    check("err_count", n_err, exp_err ? 1 : 0);
    if (exp_err) check("err_cycle", err_k, len + 3);
    sticky_model = sticky_model | exp_err;
    check("err_sticky", err_sticky, sticky_model);
    check("ready_after", ready_at, 1);
    check("ready_before", ready_before, 0);
    check("final_cnt_q", cnt_q, exp_final);

    $display("cmd start=%0d len=%0d abort_at=%0d force=%0d -> done=%0d aborted=%0d err=%0d q=%0d",
             start, len, abort_at, force_bad, n_done, n_abt, n_err, cnt_q);
  endtask

  // start a command and pull reset in the middle of RUN
  task automatic reset_mid(input int start, input int len);
    int wait_n = 0;
    while (!cmd_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    check("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_start = WIDTH'(start);
    cmd_len   = WIDTH'(len);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_in_run", cnt_enab, 1);
    $display("cmd start=%0d len=%0d interrupted by reset", start, len);
    do_reset(2);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_len   = '0;
    abort     = 1'b0;
    force_en  = 1'b0;
    force_val = '0;

    do_reset(3);

    run_cmd(3, 4, 0, 1'b0);      // basic
    run_cmd(30, 5, 0, 1'b0);     // wrap
    run_cmd(0, 31, 0, 1'b0);     // maximum length
    run_cmd(12, 0, 0, 1'b0);     // zero length
    run_cmd(0, 10, 4, 1'b0);     // abort in 3rd RUN cycle
    run_cmd(9, 0, 1, 1'b0);      // abort in LOAD
    run_cmd(5, 6, 7, 1'b0);      // abort on the last RUN cycle
    run_cmd(2, 5, 0, 1'b1);      // corrupted feedback in DONE
    run_cmd(7, 3, 0, 1'b0);      // good command, sticky must persist
    reset_mid(5, 10);            // reset clears sticky, no done/aborted

    for (int i = 0; i < 25; i++) begin
      int s, l, a;
      bit f;
      s = $urandom_range(0, MOD - 1);
      l = $urandom_range(0, MOD - 1);
      a = 0;
      f = 1'b0;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(1, l + 1);
      else f = ($urandom_range(0, 4) == 0);
      run_cmd(s, l, a, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
